// File: rtl/wallace_final_add.sv
// wallace_final_add
// Two-stage pipelined carry-propagate adder that merges the redundant sum/carry
// pair from the last carry-save row of the Wallace multiplier into one binary result.
// Stage 1 resolves the low SPLIT bits and their carry out. Stage 2 finishes the upper bits.
// Both sides use a valid/ready handshake, so the multiplier can stall without losing data.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : u/v hold a valid operand pair
//   in_ready   : operand accepted this cycle (combinational from out_ready)
//   u          : carry-save sum vector, bit i weight 2^i
//   v          : carry-save carry vector, bit i weight 2^(i+VSH)
//   out_valid  : out_sum holds a valid result
//   out_ready  : consumer takes the result this cycle
//   out_sum    : u + (v << VSH), full WU+1 bits
module wallace_final_add #(
  parameter int unsigned WU    = 10,
  parameter int unsigned WV    = 8,
  parameter int unsigned VSH   = 2,
  parameter int unsigned SPLIT = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WU-1:0] u,
  input  logic [WV-1:0] v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WU:0]   out_sum
);

  localparam int unsigned WH = WU - SPLIT;

  logic [WU-1:0]  w_w;
  logic [SPLIT:0] w_lo;
  logic [WH:0]    w_hi;
  logic           w_s1_en;
  logic           w_s2_en;
  logic           w_in_xfer;

  logic             r_s1_valid;
  logic [SPLIT-1:0] r_s1_lo;
  logic             r_s1_c1;
  logic [WH-1:0]    r_s1_uhi;
  logic [WH-1:0]    r_s1_whi;
  logic             r_s2_valid;
  logic [WU:0]      r_s2_sum;

  // Align the carry vector to its weight. Bits above WV+VSH stay zero.
  always_comb begin
    w_w                 = '0;
    w_w[WV+VSH-1:VSH]   = v;
  end

  assign w_lo = {1'b0, u[SPLIT-1:0]} + {1'b0, w_w[SPLIT-1:0]};
  assign w_hi = {1'b0, r_s1_uhi} + {1'b0, r_s1_whi} + {{WH{1'b0}}, r_s1_c1};

  // Each stage advances when it is empty or when the stage downstream of it advances.
  assign w_s2_en   = !r_s2_valid || out_ready;
  assign w_s1_en   = !r_s1_valid || w_s2_en;
  assign w_in_xfer = in_valid && w_s1_en;

  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_valid;
  assign out_sum   = r_s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_c1    <= 1'b0;
      r_s1_uhi   <= '0;
      r_s1_whi   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      // Operand fields are sampled only on a real transfer.
      if (in_valid) begin
        r_s1_lo  <= w_lo[SPLIT-1:0];
        r_s1_c1  <= w_lo[SPLIT];
        r_s1_uhi <= u[WU-1:SPLIT];
        r_s1_whi <= w_w[WU-1:SPLIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum <= {w_hi, r_s1_lo};
      end
    end
  end

endmodule

// File: tb/tb_wallace_final_add.sv
module tb_wallace_final_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  u;
  logic [7:0]  v;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] sb_q[$];
  logic        prev_stall;
  logic [10:0] prev_sum;

  typedef struct {
    logic [9:0]  u;
    logic [7:0]  v;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[7];

  wallace_final_add #(
    .WU(10),
    .WV(8),
    .VSH(2),
    .SPLIT(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .u(u),
    .v(v),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] model(input logic [9:0] a, input logic [7:0] b);
    return 11'(a) + 11'(b) * 11'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_sum", 32'(out_sum), 32'(prev_sum));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) check("sb_data", 32'(out_sum), 32'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(model(u, v));
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] e[3];
    int gaps;
    int stale;

    tbl[0] = '{10'h001, 8'h00, 11'h001};
    tbl[1] = '{10'h01F, 8'h01, 11'h023};
    tbl[2] = '{10'h3FF, 8'hFF, 11'h7FB};
    tbl[3] = '{10'h000, 8'h00, 11'h000};
    tbl[4] = '{10'h3FF, 8'h00, 11'h3FF};
    tbl[5] = '{10'h000, 8'hFF, 11'h3FC};
    tbl[6] = '{10'h155, 8'h2A, 11'h1FD};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; u = '0; v = '0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #4;
    rst_n = 1'b1;
    step();

    // Directed single transactions from the table.
    for (int i = 0; i < 7; i++) begin
      u = tbl[i].u; v = tbl[i].v; in_valid = 1'b1; out_ready = 1'b1;
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("tbl_lat_early", 32'(out_valid), 32'd0);
      step();
      check("tbl_valid", 32'(out_valid), 32'd1);
      check("tbl_sum", 32'(out_sum), 32'(tbl[i].exp));
      step();
      check("tbl_one_cycle", 32'(out_valid), 32'd0);
    end

    // Back-to-back stream.
    gaps = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      u = 10'($urandom); v = 8'($urandom); in_valid = 1'b1;
      step();
      if (k >= 1 && !out_valid) gaps++;
    end
    in_valid = 1'b0;
    step();
    if (!out_valid) gaps++;
    check("b2b_gaps", 32'(gaps), 32'd0);
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Back-pressure: out_ready low across 5 edges while offering 3 operands.
    out_ready = 1'b0;
    u = 10'($urandom); v = 8'($urandom); e[0] = model(u, v); in_valid = 1'b1;
    step();
    check("bp_not_yet", 32'(out_valid), 32'd0);
    u = 10'($urandom); v = 8'($urandom); e[1] = model(u, v);
    check("bp_ready_one", 32'(in_ready), 32'd1);
    step();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_sum0", 32'(out_sum), 32'(e[0]));
    u = 10'($urandom); v = 8'($urandom); e[2] = model(u, v);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    step();
    check("bp_hold_a", 32'(out_sum), 32'(e[0]));
    in_valid = 1'b0;
    step();
    check("bp_hold_b", 32'(out_sum), 32'(e[0]));
    in_valid = 1'b1;
    check("bp_ready_still", 32'(in_ready), 32'd0);
    step();
    check("bp_hold_c", 32'(out_sum), 32'(e[0]));
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_simul_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_sum1", 32'(out_sum), 32'(e[1]));
    check("bp_valid1", 32'(out_valid), 32'd1);
    step();
    check("bp_sum2", 32'(out_sum), 32'(e[2]));
    check("bp_valid2", 32'(out_valid), 32'd1);
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Reset mid-stream with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    u = 10'h2AB; v = 8'h5C;
    step();
    u = 10'h0F0; v = 8'hC3;
    step();
    in_valid = 1'b0;
    check("rst_prefill", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sum", 32'(out_sum), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid) stale++;
    end
    check("rst_no_stale", 32'(stale), 32'd0);
    check("rst_ready_after", 32'(in_ready), 32'd1);

    // Random soak.
    for (int k = 0; k < 10000; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      u         = 10'($urandom);
      v         = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("soak_drain", 32'(sb_q.size()), 32'd0);
    check("soak_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
